// File: rtl/weight_stream_memory_if.sv
// Weight stream / layer read bus for weight_stream_memory.
//   master (producer/consumer side): load_start, w_in, w_valid, rd_en, rd_layer
//   slave  (memory side)           : w_ready, busy, load_done, rd_valid, w_out
// w_out packs node n of the selected layer at bits [n*BIT_SIZE +: BIT_SIZE].
interface weight_stream_memory_if #(
    parameter int LAYER_SIZE  = 4,
    parameter int LAYER_DEPTH = 4,
    parameter int BIT_SIZE    = 16
);
    localparam int LW = $clog2(LAYER_DEPTH);

    logic                           load_start;
    logic [BIT_SIZE-1:0]            w_in;
    logic                           w_valid;
    logic                           w_ready;
    logic                           busy;
    logic                           load_done;
    logic                           rd_en;
    logic [LW-1:0]                  rd_layer;
    logic                           rd_valid;
    logic [LAYER_SIZE*BIT_SIZE-1:0] w_out;

    modport master (
        output load_start, w_in, w_valid, rd_en, rd_layer,
        input  w_ready, busy, load_done, rd_valid, w_out
    );

    modport slave (
        input  load_start, w_in, w_valid, rd_en, rd_layer,
        output w_ready, busy, load_done, rd_valid, w_out
    );
endinterface

// File: rtl/weight_stream_memory.sv
// Weight stream memory: a full set of LAYER_DEPTH x LAYER_SIZE weights is
// streamed in (node index fastest) after load_start, and any layer can be read
// out as one packed word with one cycle of latency while idle.
//
// Ports:
//   clk      - single clock, rising edge
//   rst      - synchronous reset, active low (storage is retained)
//   bus      - weight_stream_memory_if.slave (stream load + layer read)
//   checksum - only with WEIGHT_CHECKSUM_EN defined: running sum mod 2^BIT_SIZE
//              of words accepted since the last load start
//
// Optional feature macro: WEIGHT_CHECKSUM_EN
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | storage stable; reads serviced; load_start enters ST_LOAD
// ST_LOAD | w_ready/busy high; words written in order until the last one
module weight_stream_memory #(
    parameter int LAYER_SIZE  = 4,
    parameter int LAYER_DEPTH = 4,
    parameter int BIT_SIZE    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    weight_stream_memory_if.slave   bus
`ifdef WEIGHT_CHECKSUM_EN
    ,
    output logic [BIT_SIZE-1:0]     checksum
`endif
);
    localparam int NW = $clog2(LAYER_SIZE);
    localparam int LW = $clog2(LAYER_DEPTH);
    localparam int OW = LAYER_SIZE * BIT_SIZE;

    typedef enum logic {ST_IDLE, ST_LOAD} state_t;

    state_t              state_q, state_d;
    logic [NW-1:0]       node_q, node_d;
    logic [LW-1:0]       layer_q, layer_d;
    logic                load_done_q, load_done_d;
    logic                rd_valid_q, rd_valid_d;
    logic [OW-1:0]       w_out_q, w_out_d;
    logic [BIT_SIZE-1:0] mem_q [LAYER_DEPTH][LAYER_SIZE];

    logic                accept;
    logic                last_word;
    logic [LW-1:0]       layer_sel;
    logic [OW-1:0]       layer_word;

    assign accept    = (state_q == ST_LOAD) && bus.w_valid;
    assign last_word = (node_q == NW'(LAYER_SIZE - 1)) && (layer_q == LW'(LAYER_DEPTH - 1));

    // Out-of-range layer numbers only exist when the depth is not a power of two.
    if (LAYER_DEPTH == (1 << LW)) begin : g_sel_pow2
        assign layer_sel = bus.rd_layer;
    end else begin : g_sel_clamp
        assign layer_sel = (bus.rd_layer < LW'(LAYER_DEPTH)) ? bus.rd_layer : '0;
    end

    always_comb begin
        layer_word = '0;
        for (int n = 0; n < LAYER_SIZE; n++) begin
            layer_word[n*BIT_SIZE +: BIT_SIZE] = mem_q[layer_sel][n];
        end
    end

    always_comb begin
        state_d     = state_q;
        node_d      = node_q;
        layer_d     = layer_q;
        load_done_d = 1'b0;
        rd_valid_d  = 1'b0;
        w_out_d     = w_out_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.rd_en) begin
                    rd_valid_d = 1'b1;
                    w_out_d    = layer_word;
                end
                if (bus.load_start) begin
                    state_d = ST_LOAD;
                    node_d  = '0;
                    layer_d = '0;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    if (last_word) begin
                        state_d     = ST_IDLE;
                        node_d      = '0;
                        layer_d     = '0;
                        load_done_d = 1'b1;
                    end else if (node_q == NW'(LAYER_SIZE - 1)) begin
                        node_d  = '0;
                        layer_d = layer_q + LW'(1);
                    end else begin
                        node_d = node_q + NW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            node_q      <= '0;
            layer_q     <= '0;
            load_done_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            w_out_q     <= '0;
        end else begin
            state_q     <= state_d;
            node_q      <= node_d;
            layer_q     <= layer_d;
            load_done_q <= load_done_d;
            rd_valid_q  <= rd_valid_d;
            w_out_q     <= w_out_d;
        end
    end

    // Storage has no reset so weights survive a controller reset; a reset cycle
    // never writes.
    always_ff @(posedge clk) begin
        if (rst && accept) begin
            mem_q[layer_q][node_q] <= bus.w_in;
        end
    end

`ifdef WEIGHT_CHECKSUM_EN
    logic [BIT_SIZE-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (state_q == ST_IDLE && bus.load_start) begin
            sum_d = '0;
        end else if (accept) begin
            sum_d = sum_q + bus.w_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign checksum = sum_q;
`endif

    assign bus.w_ready   = (state_q == ST_LOAD);
    assign bus.busy      = (state_q == ST_LOAD);
    assign bus.load_done = load_done_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.w_out     = w_out_q;
endmodule

// File: tb/tb_weight_stream_memory.sv
module tb_weight_stream_memory;
    localparam int LS = 4;
    localparam int LD = 4;
    localparam int BW = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;

    weight_stream_memory_if #(.LAYER_SIZE(LS), .LAYER_DEPTH(LD), .BIT_SIZE(BW)) bus ();
    weight_stream_memory_if #(.LAYER_SIZE(LS), .LAYER_DEPTH(3),  .BIT_SIZE(BW)) bus3 ();

`ifdef WEIGHT_CHECKSUM_EN
    logic [BW-1:0] checksum;
    logic [BW-1:0] checksum3;
`endif

    weight_stream_memory #(.LAYER_SIZE(LS), .LAYER_DEPTH(LD), .BIT_SIZE(BW)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave)
`ifdef WEIGHT_CHECKSUM_EN
        ,
        .checksum (checksum)
`endif
    );

    // Non-power-of-two depth instance for out-of-range rd_layer handling.
    weight_stream_memory #(.LAYER_SIZE(LS), .LAYER_DEPTH(3), .BIT_SIZE(BW)) dut3 (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus3.slave)
`ifdef WEIGHT_CHECKSUM_EN
        ,
        .checksum (checksum3)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int done_seen = 0;

    // Reference model: flat word array indexed by accept order.
    int unsigned   m_mem [LS*LD];
    bit            m_loading;
    int            m_cnt;
    bit            m_done;
    bit            m_rdvalid;
    logic [63:0]   m_wout;
    int unsigned   m_sum;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_layer(input int l);
        logic [63:0] v = '0;
        for (int n = 0; n < LS; n++) v[n*BW +: BW] = BW'(m_mem[l*LS + n]);
        return v;
    endfunction

    task automatic model_step(input bit ls, input bit wv, input int unsigned win,
                              input bit re, input int rl, input bit rv);
        if (!rv) begin
            m_loading = 0; m_cnt = 0; m_done = 0; m_rdvalid = 0; m_wout = '0; m_sum = 0;
            return;
        end
        m_done = 0;
        if (m_loading) begin
            m_rdvalid = 0;
            if (wv) begin
                m_mem[m_cnt] = win;
                m_sum = (m_sum + win) % 65536;
                m_cnt++;
                if (m_cnt == LS*LD) begin
                    m_loading = 0; m_done = 1; m_cnt = 0;
                end
            end
        end else begin
            m_rdvalid = re;
            if (re) m_wout = model_layer((rl < LD) ? rl : 0);
            if (ls) begin
                m_loading = 1; m_cnt = 0; m_sum = 0;
            end
        end
    endtask

    task automatic cyc(input bit ls, input bit wv, input int unsigned win,
                       input bit re, input int rl, input bit rv);
        bus.load_start = ls;
        bus.w_valid    = wv;
        bus.w_in       = BW'(win);
        bus.rd_en      = re;
        bus.rd_layer   = 2'(rl);
        rst            = rv;
        @(posedge clk);
        model_step(ls, wv, win & 32'hffff, re, rl, rv);
        #1;
        if (bus.load_done) done_seen++;
        chk_eq("w_ready",   bus.w_ready,   m_loading);
        chk_eq("busy",      bus.busy,      m_loading);
        chk_eq("load_done", bus.load_done, m_done);
        chk_eq("rd_valid",  bus.rd_valid,  m_rdvalid);
        chk_eq("w_out",     bus.w_out,     m_wout);
`ifdef WEIGHT_CHECKSUM_EN
        chk_eq("checksum",  checksum,      m_sum);
`endif
    endtask

    // mode 0: continuous valid; 1: valid toggles with ignored ls/rd_en on gaps;
    // 2: random gaps and random ls/rd_en noise. first<0 means random words.
    task automatic load_seq(input int first, input int step, input int mode);
        int w = 0;
        cyc(1, 0, 0, 0, 0, 1);
        for (int k = 0; k < 400 && w < LS*LD; k++) begin
            bit v;
            int unsigned word;
            if (mode == 0)      v = 1;
            else if (mode == 1) v = (k % 2 == 0);
            else                v = ($urandom_range(0, 2) != 0);
            word = (first >= 0) ? int'(first + step*w) : $urandom_range(0, 65535);
            if (mode == 1)
                cyc(!v, v, v ? word : 16'hdead, !v, 1, 1);
            else if (mode == 2)
                cyc($urandom_range(0, 1), v, word, $urandom_range(0, 1), $urandom_range(0, 3), 1);
            else
                cyc(0, v, word, 0, 0, 1);
            if (v) w++;
        end
    endtask

    initial begin
        bus.load_start = 0; bus.w_valid = 0; bus.w_in = '0; bus.rd_en = 0; bus.rd_layer = '0;
        bus3.load_start = 0; bus3.w_valid = 0; bus3.w_in = '0; bus3.rd_en = 0; bus3.rd_layer = '0;
        for (int i = 0; i < LS*LD; i++) m_mem[i] = 0;
        m_loading = 0; m_cnt = 0; m_done = 0; m_rdvalid = 0; m_wout = '0; m_sum = 0;

        // Reset state
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 1, 5, 1, 0, 0);
        cyc(0, 1, 7, 0, 0, 1);   // w_valid in IDLE is ignored

        // Continuous load of 1..16, then read layer 2
        done_seen = 0;
        load_seq(1, 1, 0);
        chk_eq("req035_done_last", bus.load_done, 1);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 2, 1);
        chk_eq("req035_layer2", bus.w_out, {16'd12, 16'd11, 16'd10, 16'd9});
        chk_eq("req035_done_cnt", done_seen, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk_eq("rd_valid_drop", bus.rd_valid, 0);

        // Toggled valid with ignored load_start/rd_en on gap cycles
        done_seen = 0;
        load_seq(1, 1, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk_eq("req036_done_cnt", done_seen, 1);
        cyc(0, 0, 0, 1, 2, 1);
        chk_eq("req036_layer2", bus.w_out, {16'd12, 16'd11, 16'd10, 16'd9});

        // Read and load_start together in IDLE
        cyc(1, 0, 0, 1, 3, 1);
        chk_eq("req039_layer3", bus.w_out, {16'd16, 16'd15, 16'd14, 16'd13});
        chk_eq("req039_rdvalid", bus.rd_valid, 1);
        chk_eq("req039_busy", bus.busy, 1);
        for (int i = 0; i < LS*LD; i++) cyc(0, 1, i + 1, 0, 0, 1);

        // Reset after 6 words, then reload 101..116
        done_seen = 0;
        cyc(1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) cyc(0, 1, 50 + i, 0, 0, 1);
        chk_eq("req037_no_done", done_seen, 0);
        cyc(0, 1, 99, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        load_seq(101, 1, 0);
        cyc(0, 0, 0, 1, 0, 1);
        chk_eq("req037_layer0", bus.w_out, {16'd104, 16'd103, 16'd102, 16'd101});

`ifdef WEIGHT_CHECKSUM_EN
        load_seq(4096, 0, 0);
        chk_eq("req040_done", bus.load_done, 1);
        chk_eq("req040_checksum", checksum, 0);
`endif

        // Randomized loads, idle noise and reads
        for (int r = 0; r < 8; r++) begin
            load_seq(-1, 0, 2);
            for (int k = 0; k < 12; k++)
                cyc($urandom_range(0, 7) == 0 ? 1'b0 : 1'b0, $urandom_range(0, 1),
                    $urandom_range(0, 65535), $urandom_range(0, 1), $urandom_range(0, 3), 1);
            if (r == 3) begin
                cyc(1, 0, 0, 0, 0, 1);
                for (int k = 0; k < 5; k++) cyc(0, 1, $urandom_range(0, 65535), 0, 0, 1);
                cyc(0, 0, 0, 0, 0, 0);
            end
        end

        // Depth-3 instance: rd_layer=3 maps to layer 0
        bus3.load_start = 1;
        cyc(0, 0, 0, 0, 0, 1);
        bus3.load_start = 0;
        for (int i = 0; i < 12; i++) begin
            bus3.w_valid = 1;
            bus3.w_in    = BW'(201 + i);
            cyc(0, 0, 0, 0, 0, 1);
        end
        bus3.w_valid = 0;
        chk_eq("d3_done", bus3.load_done, 1);
        bus3.rd_en = 1; bus3.rd_layer = 2'd3;
        cyc(0, 0, 0, 0, 0, 1);
        chk_eq("d3_rdvalid", bus3.rd_valid, 1);
        chk_eq("d3_layer3_as_0", bus3.w_out, {16'd204, 16'd203, 16'd202, 16'd201});
        bus3.rd_layer = 2'd2;
        cyc(0, 0, 0, 0, 0, 1);
        chk_eq("d3_layer2", bus3.w_out, {16'd212, 16'd211, 16'd210, 16'd209});
        bus3.rd_en = 0;
        cyc(0, 0, 0, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/weight_stream_memory.md
WEIGHT_STREAM_MEMORY -- requirements
Module: weight_stream_memory

Interface
REQ-001 SHALL have parameter LAYER_SIZE, default 4, words per layer (nodes), >=2.
REQ-002 SHALL have parameter LAYER_DEPTH, default 4, number of layers, >=2.
REQ-003 SHALL have parameter BIT_SIZE, default 16, bits per weight word.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port load_start  input  1  request full weight reload.
REQ-007 SHALL have port w_in  input  BIT_SIZE  streamed weight word.
REQ-008 SHALL have port w_valid  input  1  w_in valid.
REQ-009 SHALL have port w_ready  output  1  block accepts w_in.
REQ-010 SHALL have port busy  output  1  high while in LOAD.
REQ-011 SHALL have port load_done  output  1  one-cycle pulse after last word is written.
REQ-012 SHALL have port rd_en  input  1  read request.
REQ-013 SHALL have port rd_layer  input  $clog2(LAYER_DEPTH)  layer to read.
REQ-014 SHALL have port rd_valid  output  1  w_out holds requested layer.
REQ-015 SHALL have port w_out  output  LAYER_SIZE x BIT_SIZE (packed)  all node weights of one layer.

Function
REQ-016 SHALL implement FSM states IDLE and LOAD; IDLE->LOAD on load_start=1 in IDLE; LOAD->IDLE in the cycle the last word is accepted.
REQ-017 SHALL assert w_ready=1 and busy=1 exactly while in LOAD.
REQ-018 SHALL accept a word only on a cycle with w_valid=1 and w_ready=1; no other cycle modifies storage.
REQ-019 SHALL write accepted words in order node 0..LAYER_SIZE-1 of layer 0, then layer 1, ..., node index fastest.
REQ-020 SHALL wrap node to 0 and increment layer after node LAYER_SIZE-1; after word LAYER_SIZE*LAYER_DEPTH-1, layer and node return to 0.
REQ-021 SHALL pulse load_done=1 for exactly one cycle, the cycle after the final word is accepted.
REQ-022 SHALL ignore load_start while in LOAD (no counter restart).
REQ-023 SHALL ignore w_valid while in IDLE (w_ready=0, no write).
REQ-024 SHALL, on rd_en=1 in IDLE, present layer rd_layer on w_out with rd_valid=1 on the next cycle (1-cycle latency).
REQ-025 SHALL ignore rd_en while in LOAD; rd_valid=0 the following cycle and w_out holds its previous value.
REQ-026 SHALL deassert rd_valid the cycle after rd_en=0; w_out holds the last read value.
REQ-027 SHALL, when load_start and rd_en are both 1 in IDLE, perform the read (rd_valid next cycle) and enter LOAD.
REQ-028 SHALL tolerate w_valid gaps of any length in LOAD without losing position.
REQ-029 SHALL treat rd_layer >= LAYER_DEPTH (non-power-of-2 depth) as layer 0.

Reset
REQ-030 SHALL, when rst=0 at a clock edge, set state IDLE, node=0, layer=0, w_ready=0, busy=0, load_done=0, rd_valid=0, w_out=0.
REQ-031 SHALL NOT clear weight storage on reset; contents are retained.
REQ-032 SHALL abort a load on reset mid-LOAD with no load_done pulse; the next load restarts at layer 0 node 0.

Configuration
REQ-033 SHALL, when WEIGHT_CHECKSUM_EN is defined, add output port checksum (BIT_SIZE): sum modulo 2^BIT_SIZE of words accepted since the last load start, cleared to 0 on reset and on IDLE->LOAD, valid when load_done=1.
REQ-034 SHALL, when WEIGHT_CHECKSUM_EN is not defined, have no checksum port or accumulator logic.

Verification (LAYER_SIZE=4, LAYER_DEPTH=4, BIT_SIZE=16)
REQ-035 SHALL cover: load_start, then 16 words 1..16 with w_valid=1 continuously -> load_done pulses one cycle after word 16; rd_layer=2 read -> w_out nodes {9,10,11,12}, rd_valid one cycle after rd_en.
REQ-036 SHALL cover: 16 words with w_valid toggled 1/0 every cycle -> same contents as REQ-035; busy=1 throughout, load_done once.
REQ-037 SHALL cover: rst=0 after 6 words, then reload with words 101..116 -> layer 0 = {101,102,103,104}, no load_done before rst.
REQ-038 SHALL cover: rd_en=1 and load_start=1 during LOAD -> rd_valid stays 0, w_out unchanged, word count unaffected.
REQ-039 SHALL cover: load_start and rd_en (rd_layer=3) together in IDLE after REQ-035 load -> w_out={13,14,15,16}, rd_valid=1 next cycle, busy=1.
REQ-040 SHALL cover, with WEIGHT_CHECKSUM_EN: words 4096 x16 -> checksum=0 (wrap at 65536) at load_done.
